// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer that owns the HI/LO pair.
// Runs a shift-add multiply or a restoring divide at one bit per cycle and
// raises busy so dependent MFHI/MFLO instructions wait for the result.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle combinational multiply).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepts MULT/MULTU/DIV/DIVU starts and MTHI/MTLO writes
// MUL   | one shift-add step per cycle, WIDTH steps
// DIV   | one restoring-divide step per cycle, WIDTH steps
// FIX   | sign correction and HI/LO write, done pulse

module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [4:0]       alu_ctrl_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0] MULT_OP  = 5'b00110;
    localparam logic [4:0] MULTU_OP = 5'b00111;
    localparam logic [4:0] DIV_OP   = 5'b01000;
    localparam logic [4:0] DIVU_OP  = 5'b01001;
    localparam logic [4:0] MTHI_OP  = 5'b10010;
    localparam logic [4:0] MTLO_OP  = 5'b10011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    // multiply: {partial product high, multiplier/product low}
    // divide:   {remainder, dividend shifting into quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   m_q, m_d;
    logic               neg_p_q, neg_p_d;
    logic               neg_r_q, neg_r_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;

    logic               op_mul, op_div, op_signed;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

    // Opcode decode, operand magnitudes and one iteration step of each datapath
    always_comb begin
        op_mul    = (alu_ctrl_op == MULT_OP) || (alu_ctrl_op == MULTU_OP);
        op_div    = (alu_ctrl_op == DIV_OP)  || (alu_ctrl_op == DIVU_OP);
        op_signed = (alu_ctrl_op == MULT_OP) || (alu_ctrl_op == DIV_OP);
        sign_a    = op_signed & src_a[WIDTH-1];
        sign_b    = op_signed & src_b[WIDTH-1];
        mag_a     = sign_a ? (~src_a + 1'b1) : src_a;
        mag_b     = sign_b ? (~src_b + 1'b1) : src_b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, m_q};
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        quo_raw  = acc_q[WIDTH-1:0];
        rem_raw  = acc_q[2*WIDTH-1:WIDTH];
        prod_fix = neg_p_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_p_q ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix  = neg_r_q ? (~rem_raw + 1'b1) : rem_raw;
    end

    // Next-state and register-update logic for the sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        m_d      = m_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (alu_ctrl_op == MTHI_OP) begin
                        hi_d = src_a;
                    end else if (alu_ctrl_op == MTLO_OP) begin
                        lo_d = src_a;
                    end else if (op_mul || op_div) begin
                        cnt_d    = '0;
                        neg_p_d  = sign_a ^ sign_b;
                        neg_r_d  = sign_a;
                        is_div_d = op_div;
                        dz_d     = 1'b0;
                        if (op_mul) begin
                            m_d = mag_a;
`ifdef MULDIV_FAST_MUL_EN
                            acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                            state_d = ST_FIX;
`else
                            acc_d   = {{WIDTH{1'b0}}, mag_b};
                            state_d = ST_MUL;
`endif
                        end else begin
                            m_d   = mag_b;
                            acc_d = {{WIDTH{1'b0}}, mag_a};
                            if (src_b == '0) begin
                                dz_d    = 1'b1;
                                state_d = ST_FIX;
                            end else begin
                                state_d = ST_DIV;
                            end
                        end
                    end
                end
            end
            ST_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) state_d = ST_FIX;
            end
            ST_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) state_d = ST_FIX;
            end
            default: begin
                if (!dz_q) begin
                    if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
        end
    end

    // Stall is combinational in the start cycle so the pipeline holds immediately
    always_comb begin
        busy   = (state_q != ST_IDLE) || (ex_valid && (op_mul || op_div));
        done   = (state_q == ST_FIX);
        hi_out = hi_q;
        lo_out = lo_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vector bench for muldiv_ctrl.
// Honors MULDIV_FAST_MUL_EN for the expected multiply latency.

module tb_muldiv_ctrl;

    localparam logic [4:0] MULT_OP  = 5'b00110;
    localparam logic [4:0] MULTU_OP = 5'b00111;
    localparam logic [4:0] DIV_OP   = 5'b01000;
    localparam logic [4:0] DIVU_OP  = 5'b01001;
    localparam logic [4:0] MTHI_OP  = 5'b10010;
    localparam logic [4:0] MTLO_OP  = 5'b10011;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYC = 2;
`else
    localparam int MUL_CYC = 34;
`endif
    localparam int DIV_CYC = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [4:0]  alu_ctrl_op = 5'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .alu_ctrl_op (alu_ctrl_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one op, optionally inject another request in cycle inj_cyc of the
    // busy window, and check latency, done pulse and final HI/LO.
    task automatic run_op(input string nm, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_cyc, input int inj_cyc,
                          input logic [4:0] inj_op, input logic [31:0] inj_a);
        int n, d_cnt, d_at;
        n = 0; d_cnt = 0; d_at = -1;
        @(posedge clk); #1;
        ex_valid = 1'b1; alu_ctrl_op = op; src_a = a; src_b = b;
        #1;
        while (busy && n < 100) begin
            n++;
            if (done) begin
                d_cnt++;
                d_at = n;
            end
            @(posedge clk); #1;
            if (n == inj_cyc) begin
                ex_valid = 1'b1; alu_ctrl_op = inj_op; src_a = inj_a; src_b = 32'd4;
            end else begin
                ex_valid = 1'b0;
            end
            #1;
        end
        ex_valid = 1'b0;
        #1;
        chk({nm, " busy_cycles"}, n, exp_cyc);
        chk({nm, " done_pulses"}, d_cnt, 1);
        chk({nm, " done_in_last"}, d_at, exp_cyc);
        chk({nm, " busy_after"}, 32'(busy), 0);
        chk({nm, " hi"}, hi_out, exp_hi);
        chk({nm, " lo"}, lo_out, exp_lo);
    endtask

    initial begin
        vecs[0] = '{"multu_max", MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_CYC};
        vecs[1] = '{"mult_neg3x7", MULT_OP, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_CYC};
        vecs[2] = '{"mult_7xneg3", MULT_OP, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_CYC};
        vecs[3] = '{"multu_shift", MULTU_OP, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, MUL_CYC};
        vecs[4] = '{"divu_100_7", DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYC};
        vecs[5] = '{"div_neg7_2", DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYC};
        vecs[6] = '{"div_ovf", DIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_CYC};
        vecs[7] = '{"div_7_neg2", DIV_OP, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, DIV_CYC};
        vecs[8] = '{"divu_max_1", DIVU_OP, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, DIV_CYC};
        vecs[9] = '{"divu_3_5", DIVU_OP, 32'd3, 32'd5, 32'd3, 32'd0, DIV_CYC};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset hi", hi_out, 0);
        chk("reset lo", lo_out, 0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc, -1, 5'd0, 32'd0);
        end

        // MTHI then MTLO back to back
        @(posedge clk); #1;
        ex_valid = 1'b1; alu_ctrl_op = MTHI_OP; src_a = 32'h12345678;
        #1 chk("mthi busy", 32'(busy), 0);
        chk("mthi hi_before", hi_out, 32'd3);
        @(posedge clk); #1;
        chk("mthi hi", hi_out, 32'h12345678);
        chk("mthi lo_kept", lo_out, 32'd0);
        chk("mthi done", 32'(done), 0);
        alu_ctrl_op = MTLO_OP; src_a = 32'h9ABCDEF0;
        #1 chk("mtlo busy", 32'(busy), 0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("mtlo lo", lo_out, 32'h9ABCDEF0);
        chk("mtlo hi_kept", hi_out, 32'h12345678);
        chk("mtlo done", 32'(done), 0);

        // Divide by zero leaves HI/LO untouched
        @(posedge clk); #1;
        ex_valid = 1'b1; alu_ctrl_op = MTHI_OP; src_a = 32'hAAAA0000;
        @(posedge clk); #1;
        alu_ctrl_op = MTLO_OP; src_a = 32'h0000BBBB;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        run_op("divu_by0", DIVU_OP, 32'd5, 32'd0, 32'hAAAA0000, 32'h0000BBBB, 2, -1, 5'd0, 32'd0);

        // MTLO issued mid-divide is ignored
        run_op("div_mtlo_mid", DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYC, 10, MTLO_OP, 32'hDEADBEEF);
        // Start in the FIX cycle of the previous op is ignored
        run_op("start_in_fix", DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYC, DIV_CYC - 1, MULTU_OP, 32'd9);

        // Reset while DIV counter is 10
        @(posedge clk); #1;
        ex_valid = 1'b1; alu_ctrl_op = DIVU_OP; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("mid_div busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid busy", 32'(busy), 0);
        chk("rst_mid done", 32'(done), 0);
        chk("rst_mid hi", hi_out, 0);
        chk("rst_mid lo", lo_out, 0);
        @(posedge clk); #1;
        chk("rst_mid stays_idle", 32'(busy), 0);
        run_op("multu_3x4", MULTU_OP, 32'd3, 32'd4, 32'd0, 32'd12, MUL_CYC, -1, 5'd0, 32'd0);

        // Reset wins over a simultaneous start
        @(posedge clk); #1;
        rst = 1'b1; ex_valid = 1'b1; alu_ctrl_op = MULTU_OP; src_a = 32'd5; src_b = 32'd5;
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0;
        #1;
        chk("rst_prio busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("rst_prio idle", 32'(busy), 0);
        chk("rst_prio lo", lo_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle sequencer for the EX-stage multiply/divide resource and the HI/LO register pair. It accepts the 5-bit ALU control code produced for MULT, MULTU, DIV, DIVU, MTHI and MTLO, and runs an iterative shift-add multiply or a restoring divide one bit per cycle. It owns HI/LO and raises a stall request to the hazard unit while a result is pending, so that a dependent MFHI/MFLO in EX waits for valid data.

## Interface
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- MULT_OP, 5'b00110, ALU code for signed multiply.
- MULTU_OP, 5'b00111, ALU code for unsigned multiply.
- DIV_OP, 5'b01000, ALU code for signed divide.
- DIVU_OP, 5'b01001, ALU code for unsigned divide.
- MTHI_OP, 5'b10010, ALU code for move-to-HI.
- MTLO_OP, 5'b10011, ALU code for move-to-LO.

Ports:
- clk  in  1  the block's one clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX-stage instruction is valid and not flushed.
- alu_ctrl_op  in  5  ALU control code of the EX instruction.
- src_a  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
- src_b  in  WIDTH  rt value: multiplier or divisor.
- hi_out  out  WIDTH  current HI register.
- lo_out  out  WIDTH  current LO register.
- busy  out  1  stall request to the hazard unit.
- done  out  1  one-cycle pulse in the FIX state.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE accepts a start when ex_valid=1 and alu_ctrl_op is one of the six codes. Any other code is ignored.
- MTHI/MTLO: HI (or LO) is loaded with src_a at the clock edge. The state stays IDLE, and busy and done are not asserted.
- MULT/MULTU/DIV/DIVU, at the edge of the start cycle:
  - Latch |src_a| and |src_b|; signed ops use two's-complement magnitude, unsigned ops use the raw value.
  - Latch the result signs: product/quotient sign is sign(a) XOR sign(b); remainder sign is sign(a). Both are 0 for unsigned ops.
  - Clear the 6-bit iteration counter.
  - Go to MUL or DIV.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator for WIDTH cycles (counter 0..WIDTH-1), then go to FIX.
- DIV: one restoring step per cycle (shift the remainder left, trial-subtract the divisor, set the quotient bit) for WIDTH cycles, then go to FIX.
- Divisor zero (DIV/DIVU): go from IDLE straight to FIX. HI/LO are left unchanged.
- FIX: apply sign correction with two's-complement negation, modulo 2^WIDTH.
  - Multiply: HI = upper half of the product, LO = lower half.
  - Divide: LO = quotient, HI = remainder.
  - Registers are written at the FIX edge, then the state returns to IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- While state is not IDLE, all new requests are ignored, including MTHI/MTLO.
- hi_out/lo_out always show the registers. Old values stay visible until the FIX write.

## Timing
- busy = (state != IDLE) OR (state == IDLE AND ex_valid AND op is MULT/MULTU/DIV/DIVU). It is combinational in the start cycle so the pipeline stalls in that same cycle.
- Iterative op: busy is high for 1 + WIDTH + 1 = 34 cycles. New HI/LO are visible in the first cycle busy is low.
- Divide by zero: busy is high for 2 cycles (start cycle and FIX).
- done is high exactly in the FIX cycle.
- Reset values:
  - state=IDLE, counter=0.
  - hi_out=0, lo_out=0, busy=0, done=0.
  - Reset mid-operation aborts the operation and discards the partial result.
- rst has priority over a simultaneous start.
- A start arriving in the same cycle as the FIX of the previous op is ignored. The hazard unit still sees busy=1 in that cycle and holds the instruction.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full 2*WIDTH product combinationally at the start edge and go IDLE -> FIX.
  - busy is high for 2 cycles.
  - DIV is unchanged.
- MULDIV_FAST_MUL_EN undefined: multiply is the iterative WIDTH-cycle shift-add described above.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. busy high for exactly 34 cycles (2 with MULDIV_FAST_MUL_EN), done single pulse.
- MULT 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIVU 100 / 7 -> LO=14, HI=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI=0xAAAA0000, LO=0x0000BBBB; DIVU 5 / 0 -> HI/LO unchanged, busy high 2 cycles, done pulses.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles:
  - hi_out/lo_out update one cycle after each, busy never asserted.
  - MTLO issued mid-DIV is ignored.
- Reset asserted at counter=10 of a DIV:
  - Next cycle busy=0, state IDLE, HI=LO=0.
  - A subsequent MULTU 3 × 4 gives LO=12, HI=0.
